opal_lane_tx: RTL and testbench

- Parallel-lane serial transmitter from the FPGA to the OPAL-RT simulator. It is the send-direction counterpart of the OPAL receive path.
- Takes QTD_VARIABLES_SEND words of OPAL_OUTPUT_WIDTH bits. Shifts each word MSB-first on its own data lane.
- Generates the serial clock and frame enable on the same output bus, so the simulink-side receiver sees {clk, enable, lanes}.
- Sits between the AXI register block (source of the words) and the FPGA pins toward OPAL.

---
 rtl/opal_lane_tx.sv | 159 +++++++++++++++
 tb/tb_opal_lane_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/opal_lane_tx.sv
// Parallel-lane serial transmitter toward OPAL-RT: shifts one word per lane MSB-first
// and drives {serial clock, frame enable, lanes} on a single output bus.
module opal_lane_tx #(
  parameter int QTD_VARIABLES_SEND = 14,
  parameter int OPAL_OUTPUT_WIDTH  = 16,
  parameter int CLK_DIV            = 4,
  parameter int GAP_BITS           = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [QTD_VARIABLES_SEND*OPAL_OUTPUT_WIDTH-1:0] i_data,
  input  logic                                          i_valid,
  output logic                                          o_ready,
  output logic [QTD_VARIABLES_SEND+1:0]                 o_data_tx,
  output logic                                          o_busy,
  output logic                                          o_frame_done,
  output logic [3:0]                                    state_watch
);

  localparam int Q       = QTD_VARIABLES_SEND;
  localparam int W       = OPAL_OUTPUT_WIDTH;
  localparam int GAP_LEN = GAP_BITS * 2 * CLK_DIV;
  localparam int BIT_CW  = $clog2(W + 1);
  localparam int DIV_CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_CW  = $clog2(GAP_LEN + 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    SEND = 4'd1,
    GAP  = 4'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DIV_CW-1:0]   div_reg, div_next;
  logic [BIT_CW-1:0]   bit_reg, bit_next;
  logic [GAP_CW-1:0]   gap_reg, gap_next;
  logic                sclk_reg, sclk_next;
  logic                enable_reg;
  logic                busy_reg;
  logic                frame_done_reg, frame_done_next;
  logic                load, shift, clear;
  logic                div_tc;
  logic [Q-1:0]        lanes;
  logic [W-1:0]        shift_reg [Q];

  assign div_tc = (div_reg == DIV_CW'(CLK_DIV - 1));

  always_comb begin
    state_next      = state_reg;
    div_next        = div_reg;
    bit_next        = bit_reg;
    gap_next        = gap_reg;
    sclk_next       = sclk_reg;
    frame_done_next = 1'b0;
    load            = 1'b0;
    shift           = 1'b0;
    clear           = 1'b0;
    case (state_reg)
      IDLE: begin
        sclk_next = 1'b0;
        div_next  = '0;
        bit_next  = '0;
        gap_next  = '0;
        if (i_valid) begin
          state_next = SEND;
          load       = 1'b1;
        end
      end
      SEND: begin
        if (div_tc) begin
          div_next  = '0;
          sclk_next = ~sclk_reg;
          // falling edge: lanes advance together with the clock
          if (sclk_reg) begin
            shift = 1'b1;
            if (bit_reg == BIT_CW'(W - 1)) begin
              state_next = GAP;
              bit_next   = '0;
              gap_next   = '0;
              clear      = 1'b1;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      GAP: begin
        if (div_tc) begin
          div_next  = '0;
          sclk_next = ~sclk_reg;
        end else begin
          div_next = div_reg + 1'b1;
        end
        if (gap_reg == GAP_CW'(GAP_LEN - 1)) begin
          state_next      = IDLE;
          sclk_next       = 1'b0;
          div_next        = '0;
          gap_next        = '0;
          frame_done_next = 1'b1;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        sclk_next  = 1'b0;
        clear      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      div_reg        <= '0;
      bit_reg        <= '0;
      gap_reg        <= '0;
      sclk_reg       <= 1'b0;
      enable_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_reg        <= div_next;
      bit_reg        <= bit_next;
      gap_reg        <= gap_next;
      sclk_reg       <= sclk_next;
      enable_reg     <= (state_next == SEND);
      busy_reg       <= (state_next != IDLE);
      frame_done_reg <= frame_done_next;
    end
  end

  generate
    for (genvar gi = 0; gi < Q; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shift_reg[gi] <= '0;
        end else if (load) begin
          shift_reg[gi] <= i_data[gi*W +: W];
        end else if (clear) begin
          shift_reg[gi] <= '0;
        end else if (shift) begin
          shift_reg[gi] <= shift_reg[gi] << 1;
        end
      end
      assign lanes[gi] = shift_reg[gi][W-1];
    end
  endgenerate

  assign o_ready      = (state_reg == IDLE) && rst_n;
  assign o_data_tx    = {sclk_reg, enable_reg, lanes};
  assign o_busy       = busy_reg;
  assign o_frame_done = frame_done_reg;
  assign state_watch  = state_reg;

endmodule

// File: tb/tb_opal_lane_tx.sv
// Directed + randomized bench for opal_lane_tx: decodes the serial bus back into words
// and checks frame timing against the expected frame arithmetic.
module tb_opal_lane_tx;
  localparam int Q = 14;
  localparam int W = 16;
  localparam int C = 2;
  localparam int G = 2;
  localparam int EN_LEN   = 2 * W * C;
  localparam int GAP_LEN  = 2 * G * C;
  localparam int DONE_LAT = (W + G) * 2 * C + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [Q*W-1:0]   i_data = '0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [Q+1:0]     o_data_tx;
  logic             o_busy;
  logic             o_frame_done;
  logic [3:0]       state_watch;

  int total = 0;
  int bad = 0;

  opal_lane_tx #(
    .QTD_VARIABLES_SEND(Q), .OPAL_OUTPUT_WIDTH(W), .CLK_DIV(C), .GAP_BITS(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data_tx(o_data_tx), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .state_watch(state_watch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 64'(o_ready), 64'd1);
  endtask

  function automatic logic [Q*W-1:0] rand_frame();
    logic [Q*W-1:0] d;
    for (int l = 0; l < Q; l++) d[l*W +: W] = W'($urandom);
    return d;
  endfunction

  // Sends one frame, decodes it from sclk rising edges and checks timing.
  task automatic run_frame(input string name, input logic [Q*W-1:0] data, input bit poke);
    logic [W-1:0] cap [Q];
    int en_cnt = 0, gap_cnt = 0, done_at = -1, done_cnt = 0, rises = 0;
    logic prev_sclk = 1'b0;
    for (int l = 0; l < Q; l++) cap[l] = '0;
    wait_ready();
    i_data  = data;
    i_valid = 1'b1;
    for (int k = 1; k <= DONE_LAT + 15; k++) begin
      @(negedge clk);
      if (k == 1) i_valid = 1'b0;
      if (o_data_tx[Q]) en_cnt++;
      if (o_busy && !o_data_tx[Q]) gap_cnt++;
      if (o_frame_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (o_data_tx[Q+1] && !prev_sclk && o_data_tx[Q]) begin
        rises++;
        for (int l = 0; l < Q; l++) cap[l] = {cap[l][W-2:0], o_data_tx[l]};
      end
      prev_sclk = o_data_tx[Q+1];
      if (poke && k == 20) begin
        chk({name, "_ready_in_send"}, 64'(o_ready), 64'd0);
        i_data  = ~data;
        i_valid = 1'b1;
      end
      if (poke && k == 21) i_valid = 1'b0;
    end
    for (int l = 0; l < Q; l++)
      chk($sformatf("%s_lane%0d", name, l), 64'(cap[l]), 64'(data[l*W +: W]));
    chk({name, "_rises"}, 64'(rises), 64'(W));
    chk({name, "_enable_len"}, 64'(en_cnt), 64'(EN_LEN));
    chk({name, "_gap_len"}, 64'(gap_cnt), 64'(GAP_LEN));
    chk({name, "_done_lat"}, 64'(done_at), 64'(DONE_LAT));
    chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
    $display("frame %s: rises=%0d en=%0d gap=%0d done_at=%0d", name, rises, en_cnt, gap_cnt, done_at);
  endtask

  initial begin
    logic [Q*W-1:0] d;
    int first_rise, second_rise, busy_low, gap_en_low, rises, done_seen;
    logic prev_en, prev_sclk;

    // reset with i_valid asserted
    i_valid = 1'b1;
    i_data  = rand_frame();
    repeat (4) @(negedge clk);
    chk("rst_data_tx", 64'(o_data_tx), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_state", 64'(state_watch), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    i_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(o_ready), 64'd1);
    $display("reset released: ready=%0b state=%0d", o_ready, state_watch);

    d = '0;
    d[0 +: W] = 16'hA5C3;
    run_frame("single", d, 1'b0);

    for (int l = 0; l < Q; l++) d[l*W +: W] = 16'(16'h1111 * l);
    run_frame("distinct", d, 1'b0);

    run_frame("rand0", rand_frame(), 1'b0);
    run_frame("midpoke", rand_frame(), 1'b1);
    run_frame("rand1", rand_frame(), 1'b0);

    // back-to-back with i_valid held
    wait_ready();
    i_data = rand_frame();
    i_valid = 1'b1;
    first_rise = -1; second_rise = -1; busy_low = 0; gap_en_low = 0;
    prev_en = 1'b0;
    for (int k = 1; k <= 2 * DONE_LAT + 20; k++) begin
      @(negedge clk);
      if (o_data_tx[Q] && !prev_en) begin
        if (first_rise < 0) first_rise = k;
        else if (second_rise < 0) begin
          second_rise = k;
          i_valid = 1'b0;
        end
      end
      if (first_rise >= 0 && second_rise < 0) begin
        if (!o_busy) busy_low++;
        if (o_busy && !o_data_tx[Q]) gap_en_low++;
      end
      prev_en = o_data_tx[Q];
    end
    i_valid = 1'b0;
    chk("b2b_period", 64'(second_rise - first_rise), 64'(DONE_LAT));
    chk("b2b_gap", 64'(gap_en_low), 64'(GAP_LEN));
    chk("b2b_idle", 64'(busy_low), 64'd1);
    $display("back-to-back: period=%0d gap=%0d idle=%0d", second_rise - first_rise, gap_en_low, busy_low);

    // async reset at bit 7, between clock edges
    wait_ready();
    i_data = rand_frame();
    i_valid = 1'b1;
    rises = 0; prev_sclk = 1'b0;
    for (int k = 1; k < EN_LEN && rises < 7; k++) begin
      @(negedge clk);
      i_valid = 1'b0;
      if (o_data_tx[Q+1] && !prev_sclk) rises++;
      prev_sclk = o_data_tx[Q+1];
    end
    chk("abort_reached_bit7", 64'(rises), 64'd7);
    chk("abort_pre_enable", 64'(o_data_tx[Q]), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_data_tx", 64'(o_data_tx), 64'd0);
    chk("abort_done", 64'(o_frame_done), 64'd0);
    chk("abort_state", 64'(state_watch), 64'd0);
    chk("abort_ready", 64'(o_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < DONE_LAT + 5; k++) begin
      @(negedge clk);
      if (o_frame_done) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    $display("abort: data_tx cleared, done pulses after release=%0d", done_seen);

    run_frame("post_abort", rand_frame(), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
